// File: rtl/dmem_arbiter_if.sv
// Bundle for the data-memory arbiter: two requester ports plus the memory-side bus.
// The arbiter binds to the slave modport; whatever drives the requests and models memory binds to master.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output ack0, rdata0, ack1, rdata1,
    output mem_addr, mem_wdata, mem_rd, mem_wr, busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the processor port (0)
// and the debug/loader port (1); each access runs SETUP -> STROBE -> CAPTURE -> ACK.
module dmem_arbiter #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int STROBE_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    CAPTURE,
    ACK
  } stateT;

  localparam logic [3:0] CNT_INIT = 4'(STROBE_CYCLES - 1);

  stateT             stateReg, stateNext;
  logic [3:0]        cntReg, cntNext;
  logic [1:0]        reqSampledReg;
  logic [1:0]        reqLive;
  logic [1:0]        reqValid;
  logic              lastGrantReg;
  logic              grantReg;
  logic              weReg;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] wdataReg;
  logic [DATA_W-1:0] rdataReg [2];

  logic              winPort;
  logic              loadGrant;
  logic              captureRead;
  logic              memRd;
  logic              memWr;
  logic [1:0]        ackVec;

  // Requests are registered one edge before arbitration; a request only counts while it is
  // still asserted live, so a requester that drops req before grant is simply withdrawn.
  assign reqLive  = {bus.req1, bus.req0};
  assign reqValid = reqLive & reqSampledReg;

  always_comb begin
    winPort = 1'b0;
    case (reqValid)
      2'b01:   winPort = 1'b0;
      2'b10:   winPort = 1'b1;
      2'b11:   winPort = ~lastGrantReg;
      default: winPort = 1'b0;
    endcase
  end

  always_comb begin
    stateNext   = stateReg;
    cntNext     = cntReg;
    loadGrant   = 1'b0;
    captureRead = 1'b0;
    memRd       = 1'b0;
    memWr       = 1'b0;
    ackVec      = 2'b00;
    case (stateReg)
      IDLE: begin
        if (|reqValid) begin
          loadGrant = 1'b1;
          stateNext = SETUP;
        end
      end
      SETUP: begin
        cntNext   = CNT_INIT;
        stateNext = STROBE;
      end
      STROBE: begin
        memWr = weReg;
        memRd = ~weReg;
        if (cntReg == 4'd0) begin
          stateNext = CAPTURE;
        end else begin
          cntNext = cntReg - 4'd1;
        end
      end
      CAPTURE: begin
        captureRead = ~weReg;
        stateNext   = ACK;
      end
      ACK: begin
        ackVec[grantReg] = 1'b1;
        stateNext        = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg      <= IDLE;
      cntReg        <= '0;
      reqSampledReg <= '0;
      lastGrantReg  <= 1'b1;
      grantReg      <= 1'b0;
      weReg         <= 1'b0;
      addrReg       <= '0;
      wdataReg      <= '0;
    end else begin
      stateReg      <= stateNext;
      cntReg        <= cntNext;
      reqSampledReg <= reqLive;
      // Fields are frozen at grant so the memory sees stable address/data for the whole access.
      if (loadGrant) begin
        grantReg     <= winPort;
        lastGrantReg <= winPort;
        weReg        <= winPort ? bus.we1    : bus.we0;
        addrReg      <= winPort ? bus.addr1  : bus.addr0;
        wdataReg     <= winPort ? bus.wdata1 : bus.wdata0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        rdataReg[i] <= '0;
      end else if (captureRead && (grantReg == 1'(i))) begin
        rdataReg[i] <= bus.mem_rdata;
      end
    end
  end

  assign bus.ack0      = ackVec[0];
  assign bus.ack1      = ackVec[1];
  assign bus.rdata0    = rdataReg[0];
  assign bus.rdata1    = rdataReg[1];
  assign bus.mem_addr  = addrReg;
  assign bus.mem_wdata = wdataReg;
  assign bus.mem_rd    = memRd;
  assign bus.mem_wr    = memWr;
  assign bus.busy      = (stateReg != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: one instance with a 1-cycle strobe, one with a 3-cycle strobe,
// each attached to a small behavioural memory.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checkCount = 0;
  int   errCount = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) busA ();
  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) busB ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .STROBE_CYCLES(1)) dutA (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busA)
  );

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .STROBE_CYCLES(3)) dutB (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busB)
  );

  typedef struct {
    logic       port;
    logic [7:0] rdata;
    int         cyc;
  } expT;

  expT        qA[$];
  expT        qB[$];
  logic [7:0] memA [256];
  logic [7:0] memB [256];
  logic [7:0] refMem [256];
  logic [7:0] expRd0 = 8'h00;
  logic [7:0] expRd1 = 8'h00;

  int         runA = 0, lastRunA = 0, pulsesA = 0;
  int         runB = 0, lastRunB = 0, pulsesB = 0;
  logic [7:0] sAddrA = 8'h00, sDataA = 8'h00;
  logic       sWrA = 1'b0, sWrB = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Behavioural memories with registered read data
  initial begin
    busA.mem_rdata = 8'h00;
    busB.mem_rdata = 8'h00;
    memB[8'h33]    = 8'hC3;
  end

  always @(posedge clk) begin
    if (busA.mem_wr) memA[busA.mem_addr] <= busA.mem_wdata;
    if (busA.mem_rd) busA.mem_rdata <= memA[busA.mem_addr];
    if (busB.mem_wr) memB[busB.mem_addr] <= busB.mem_wdata;
    if (busB.mem_rd) busB.mem_rdata <= memB[busB.mem_addr];
  end

  // Output monitors: pop the scoreboard on every ack, track strobe pulses
  always @(negedge clk) begin
    expT e;
    if (rst_n && (busA.ack0 || busA.ack1)) begin
      checkVal("ackExclA", 32'(busA.ack0 & busA.ack1), 32'd0);
      if (qA.size() == 0) begin
        checkVal("unexpAckA", 32'd1, 32'd0);
      end else begin
        e = qA.pop_front();
        checkVal("ackPortA", 32'(busA.ack1), 32'(e.port));
        checkVal("rdataA", 32'(busA.ack1 ? busA.rdata1 : busA.rdata0), 32'(e.rdata));
        checkVal("ackCycA", 32'(cyc), 32'(e.cyc));
      end
    end
    if (busA.mem_rd || busA.mem_wr) begin
      checkVal("strobeExclA", 32'(busA.mem_rd & busA.mem_wr), 32'd0);
      runA++;
      sAddrA = busA.mem_addr;
      sDataA = busA.mem_wdata;
      sWrA   = busA.mem_wr;
    end else if (runA > 0) begin
      lastRunA = runA;
      pulsesA++;
      runA = 0;
    end
  end

  always @(negedge clk) begin
    expT e;
    if (rst_n && (busB.ack0 || busB.ack1)) begin
      checkVal("ackExclB", 32'(busB.ack0 & busB.ack1), 32'd0);
      if (qB.size() == 0) begin
        checkVal("unexpAckB", 32'd1, 32'd0);
      end else begin
        e = qB.pop_front();
        checkVal("ackPortB", 32'(busB.ack1), 32'(e.port));
        checkVal("rdataB", 32'(busB.ack1 ? busB.rdata1 : busB.rdata0), 32'(e.rdata));
        checkVal("ackCycB", 32'(cyc), 32'(e.cyc));
      end
    end
    if (busB.mem_rd || busB.mem_wr) begin
      runB++;
      sWrB = busB.mem_wr;
    end else if (runB > 0) begin
      lastRunB = runB;
      pulsesB++;
      runB = 0;
    end
  end

  task automatic driveA(input logic port, input logic req, input logic we,
                        input logic [7:0] addr, input logic [7:0] wdata);
    if (port) begin
      busA.req1 = req; busA.we1 = we; busA.addr1 = addr; busA.wdata1 = wdata;
    end else begin
      busA.req0 = req; busA.we0 = we; busA.addr0 = addr; busA.wdata0 = wdata;
    end
  endtask

  // Single access on bus A; ack expected in the cycle after edge k+4 (k = first edge seeing req)
  task automatic accessA(input logic port, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, input bit mutate);
    int         p;
    bit         seen;
    logic [7:0] expR;
    @(posedge clk); #1;
    p = cyc;
    if (we) begin
      refMem[addr] = wdata;
      expR = port ? expRd1 : expRd0;
    end else begin
      expR = refMem[addr];
      if (port) expRd1 = expR; else expRd0 = expR;
    end
    driveA(port, 1'b1, we, addr, wdata);
    qA.push_back('{port, expR, p + 5});
    $display("access port%0d %s addr=%02h wdata=%02h expect rdata=%02h at cycle %0d",
             port, we ? "WR" : "RD", addr, wdata, expR, p + 5);
    seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      if (busA.busy) checkVal("memAddrHold", 32'(busA.mem_addr), 32'(addr));
      if (mutate && (busA.mem_wr || busA.mem_rd)) driveA(port, 1'b1, we, addr + 8'h10, ~wdata);
      if (port ? busA.ack1 : busA.ack0) begin
        seen = 1'b1;
        driveA(port, 1'b0, we, addr, wdata);
      end
    end
    checkVal("ackSeen", 32'(seen), 32'd1);
    driveA(port, 1'b0, we, addr, wdata);
    @(posedge clk);
  endtask

  // Both ports request on the same edge and hold; port 0 writes, port 1 reads the same line
  task automatic runTie(input int n, input logic [7:0] addr, input logic [7:0] wdata);
    int p, got0, got1, q0, q1;
    q0 = (n + 1) / 2;
    q1 = n / 2;
    @(posedge clk); #1;
    p = cyc;
    refMem[addr] = wdata;
    driveA(1'b0, 1'b1, 1'b1, addr, wdata);
    driveA(1'b1, 1'b1, 1'b0, addr, 8'h00);
    for (int i = 0; i < n; i++) begin
      qA.push_back('{1'(i % 2), (i % 2) ? wdata : expRd0, p + 5 + 5 * i});
      $display("tie access %0d expect port%0d at cycle %0d", i, i % 2, p + 5 + 5 * i);
    end
    got0 = 0;
    got1 = 0;
    for (int t = 0; t < 30 * n && (got0 + got1) < n; t++) begin
      @(negedge clk);
      if (busA.ack0) begin got0++; if (got0 >= q0) busA.req0 = 1'b0; end
      if (busA.ack1) begin got1++; if (got1 >= q1) busA.req1 = 1'b0; end
    end
    checkVal("tieAcks", 32'(got0 + got1), 32'(n));
    busA.req0 = 1'b0;
    busA.req1 = 1'b0;
    expRd1 = wdata;
    @(posedge clk);
  endtask

  initial begin
    int         pA, pB, p;
    bit         seen;
    driveA(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    driveA(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    busB.req0 = 1'b0; busB.we0 = 1'b0; busB.addr0 = 8'h00; busB.wdata0 = 8'h00;
    busB.req1 = 1'b0; busB.we1 = 1'b0; busB.addr1 = 8'h00; busB.wdata1 = 8'h00;
    for (int i = 0; i < 256; i++) refMem[i] = 8'h00;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rstBusy", 32'(busA.busy), 32'd0);
    checkVal("rstAcks", 32'({busA.ack1, busA.ack0}), 32'd0);
    checkVal("rstStrobes", 32'({busA.mem_rd, busA.mem_wr}), 32'd0);
    checkVal("rstRdata", 32'({busA.rdata1, busA.rdata0}), 32'd0);
    checkVal("rstMemAddr", 32'(busA.mem_addr), 32'd0);
    checkVal("rstBusyB", 32'(busB.busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);

    // Simultaneous held requests alternate 0,1,0,1
    pA = pulsesA;
    runTie(4, 8'h40, 8'h11);
    checkVal("tiePulses", 32'(pulsesA - pA), 32'd4);

    // Port 0 write
    pA = pulsesA;
    accessA(1'b0, 1'b1, 8'h10, 8'hA5, 1'b0);
    checkVal("t1Pulses", 32'(pulsesA - pA), 32'd1);
    checkVal("t1RunLen", 32'(lastRunA), 32'd1);
    checkVal("t1StrAddr", 32'(sAddrA), 32'h10);
    checkVal("t1StrData", 32'(sDataA), 32'hA5);
    checkVal("t1StrWr", 32'(sWrA), 32'd1);

    // Port 1 read back
    pA = pulsesA;
    accessA(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    checkVal("t2Pulses", 32'(pulsesA - pA), 32'd1);
    checkVal("t2StrWr", 32'(sWrA), 32'd0);
    repeat (10) @(negedge clk);
    checkVal("t2Hold", 32'(busA.rdata1), 32'hA5);

    // Fields changing mid-access are ignored
    accessA(1'b0, 1'b1, 8'h20, 8'h42, 1'b1);
    checkVal("t4StrAddr", 32'(sAddrA), 32'h20);
    checkVal("t4StrData", 32'(sDataA), 32'h42);
    accessA(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);

    // Request withdrawn before grant: no access
    pA = pulsesA;
    @(posedge clk); #1;
    driveA(1'b0, 1'b1, 1'b1, 8'h60, 8'h66);
    @(posedge clk); #1;
    driveA(1'b0, 1'b0, 1'b1, 8'h60, 8'h66);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      checkVal("wdrawBusy", 32'(busA.busy), 32'd0);
    end
    checkVal("wdrawPulses", 32'(pulsesA - pA), 32'd0);

    // Reset during the strobe of a write
    @(posedge clk); #1;
    driveA(1'b0, 1'b1, 1'b1, 8'h77, 8'h99);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (busA.mem_wr) seen = 1'b1;
    end
    checkVal("t5SawStrobe", 32'(seen), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkVal("t5MemWr", 32'(busA.mem_wr), 32'd0);
    checkVal("t5Busy", 32'(busA.busy), 32'd0);
    checkVal("t5Acks", 32'({busA.ack1, busA.ack0}), 32'd0);
    checkVal("t5Rdata0", 32'(busA.rdata0), 32'd0);
    checkVal("t5Rdata1", 32'(busA.rdata1), 32'd0);
    driveA(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    expRd0 = 8'h00;
    expRd1 = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    runTie(2, 8'h50, 8'h5A);

    // Three-cycle strobe instance, port 1 read: ack at k+6
    pB = pulsesB;
    @(posedge clk); #1;
    p = cyc;
    busB.we1 = 1'b0; busB.addr1 = 8'h33; busB.req1 = 1'b1;
    qB.push_back('{1'b1, 8'hC3, p + 7});
    $display("access B port1 RD addr=33 expect rdata=c3 at cycle %0d", p + 7);
    seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      if (busB.ack1) begin seen = 1'b1; busB.req1 = 1'b0; end
    end
    checkVal("t6AckSeen", 32'(seen), 32'd1);
    busB.req1 = 1'b0;
    checkVal("t6Pulses", 32'(pulsesB - pB), 32'd1);
    checkVal("t6RunLen", 32'(lastRunB), 32'd3);
    checkVal("t6StrWr", 32'(sWrB), 32'd0);

    // Drain scoreboards
    for (int t = 0; t < 50 && (qA.size() + qB.size()) > 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    checkVal("drainA", 32'(qA.size()), 32'd0);
    checkVal("drainB", 32'(qB.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
